appr_mult_sweep_ctrl: RTL and testbench

//   Hardware sweep controller for characterising an N-bit approximate multiplier.

---
 rtl/appr_mult_sweep_ctrl.sv | 101 ++++++++++
 tb/tb_appr_mult_sweep_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/appr_mult_sweep_ctrl.sv
// Exhaustive operand sweep for an external approximate multiplier.
// Streams {a, b, product} per pair and accumulates error metrics.
module appr_mult_sweep_ctrl #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic [N-1:0]   op_a,
  output logic [N-1:0]   op_b,
  input  logic [2*N-1:0] appr_prod,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [4*N-1:0] res_data,
  output logic           busy,
  output logic           done,
  output logic [2*N:0]   err_cnt,
  output logic [4*N-1:0] err_sum,
  output logic [2*N-1:0] err_max
);

  localparam int W = 2 * N;
  localparam logic [N-1:0] OP_MAX = '1;
  localparam logic [N-1:0] OP_ONE = 1;
  localparam logic [W:0] CNT_ONE = 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic         slot_free;
  logic         cap;
  logic         last;
  logic [W-1:0] exact;
  logic [W-1:0] diff;

  assign slot_free = !res_valid || res_ready;
  assign cap       = (state == RUN) && slot_free;
  assign last      = (op_a == OP_MAX) && (op_b == OP_MAX);
  assign exact     = {{N{1'b0}}, op_a} * {{N{1'b0}}, op_b};
  assign diff      = (appr_prod >= exact) ? appr_prod - exact
                                          : exact - appr_prod;
  assign busy      = (state == RUN) || (state == DRAIN);
  assign done      = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cap && last) state_nxt = DRAIN;
      DRAIN:   if (res_valid && res_ready) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a      <= '0;
      op_b      <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      err_cnt   <= '0;
      err_sum   <= '0;
      err_max   <= '0;
    end else begin
      if (state == IDLE && start) begin
        op_a    <= '0;
        op_b    <= '0;
        err_cnt <= '0;
        err_sum <= '0;
        err_max <= '0;
      end
      if (cap) begin
        res_data  <= {op_a, op_b, appr_prod};
        res_valid <= 1'b1;
        if (diff != '0) err_cnt <= err_cnt + CNT_ONE;
        err_sum <= err_sum + {{W{1'b0}}, diff};
        if (diff > err_max) err_max <= diff;
        // Operands park on the last pair while the final result drains.
        if (!last) begin
          op_b <= op_b + OP_ONE;
          if (op_b == OP_MAX) op_a <= op_a + OP_ONE;
        end
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_appr_mult_sweep_ctrl.sv
// Bench for appr_mult_sweep_ctrl: scoreboard of expected results
// per sweep, checked against every accepted transfer.
module tb_appr_mult_sweep_ctrl;

  localparam int N = 4;

  logic         clk = 0;
  logic         rst = 1;
  logic         start = 0;
  logic [3:0]   op_a, op_b;
  logic [7:0]   appr_prod;
  logic         res_valid;
  logic         res_ready = 1;
  logic [15:0]  res_data;
  logic         busy, done;
  logic [8:0]   err_cnt;
  logic [15:0]  err_sum;
  logic [7:0]   err_max;

  logic         model_lsb = 0;
  logic [7:0]   ex_prod;

  int n_tests = 0;
  int n_fail  = 0;
  int xfers   = 0;
  int done_cnt = 0;
  bit mon_en  = 1;
  logic [15:0] seen35 = '0;
  logic [15:0] exp_q[$];
  int exp_cnt, exp_sum, exp_max;

  appr_mult_sweep_ctrl #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start),
    .op_a(op_a), .op_b(op_b), .appr_prod(appr_prod),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .busy(busy), .done(done),
    .err_cnt(err_cnt), .err_sum(err_sum), .err_max(err_max)
  );

  always #5 clk = ~clk;

  assign ex_prod   = {4'b0, op_a} * {4'b0, op_b};
  assign appr_prod = model_lsb ? (ex_prod & 8'hFE) : ex_prod;

  // Transfer seen at negedge completes at the following posedge.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (done) done_cnt++;
      if (res_valid && res_ready) begin
        logic [15:0] e;
        xfers++;
        n_tests++;
        if (res_data[15:8] == 8'h35) seen35 = res_data;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL xfer_extra: got %h, none expected", res_data);
        end else begin
          e = exp_q.pop_front();
          if (res_data !== e) begin
            n_fail++;
            $display("FAIL xfer_data #%0d: got %h, expected %h",
                     xfers, res_data, e);
          end
        end
      end
    end
  end

  task automatic start_sweep(input bit lsb);
    int p, d;
    model_lsb = lsb;
    exp_q.delete();
    xfers = 0;
    done_cnt = 0;
    exp_cnt = 0;
    exp_sum = 0;
    exp_max = 0;
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++) begin
        p = lsb ? ((a * b) & 'hFE) : a * b;
        d = a * b - p;
        if (d != 0) exp_cnt++;
        exp_sum += d;
        if (d > exp_max) exp_max = d;
        exp_q.push_back({a[3:0], b[3:0], p[7:0]});
      end
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    n_tests++;
    while (cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      if (done) break;
    end
    if (!done) begin
      n_fail++;
      $display("FAIL done_timeout: got done=%b after %0d cycles, expected 1",
               done, cyc);
    end
  endtask

  task automatic test_reset;
    rst = 1;
    #2;
    n_tests++;
    if ({op_a, op_b, res_valid, res_data, busy, done,
         err_cnt, err_sum, err_max} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: op=%h/%h v=%b d=%h busy=%b done=%b m=%h/%h/%h, expected all 0",
               op_a, op_b, res_valid, res_data, busy, done,
               err_cnt, err_sum, err_max);
    end
    @(posedge clk); #1 rst = 0;
  endtask

  task automatic test_exact;
    int cyc;
    start_sweep(0);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL exact_busy: got %b, expected 1", busy);
    end
    wait_done(cyc);
    n_tests++;
    if (cyc !== 257) begin
      n_fail++;
      $display("FAIL exact_done_cycle: got %0d, expected 257", cyc);
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL exact_busy_done: got %b, expected 0", busy);
    end
    n_tests++;
    if ({err_cnt, err_sum, err_max} !== '0) begin
      n_fail++;
      $display("FAIL exact_metrics: got %0d/%0d/%0d, expected 0/0/0",
               err_cnt, err_sum, err_max);
    end
    @(posedge clk); #1;
    n_tests++;
    if (done !== 1'b0 || done_cnt !== 1) begin
      n_fail++;
      $display("FAIL exact_done_pulse: got done=%b count=%0d, expected 0/1",
               done, done_cnt);
    end
    n_tests++;
    if (xfers !== 256 || exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL exact_xfers: got %0d left %0d, expected 256/0",
               xfers, exp_q.size());
    end
  endtask

  task automatic test_lsb_zero;
    int cyc;
    seen35 = '0;
    start_sweep(1);
    wait_done(cyc);
    n_tests++;
    if (err_cnt !== 9'd64 || err_sum !== 16'd64 || err_max !== 8'd1) begin
      n_fail++;
      $display("FAIL lsb_metrics: got %0d/%0d/%0d, expected 64/64/1",
               err_cnt, err_sum, err_max);
    end
    @(posedge clk); #1;
    n_tests++;
    if (seen35 !== 16'h350E) begin
      n_fail++;
      $display("FAIL lsb_pair_3x5: got %h, expected 350e", seen35);
    end
    n_tests++;
    if (xfers !== 256 || exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL lsb_xfers: got %0d left %0d, expected 256/0",
               xfers, exp_q.size());
    end
  endtask

  task automatic test_backpressure;
    int cyc, k;
    start_sweep(1);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(op_a == 0 && op_b == 5 && res_valid && res_ready) && k < 100);
    @(posedge clk); #1 res_ready = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if (res_data !== 16'h0500 || res_valid !== 1'b1 ||
          op_a !== 4'd0 || op_b !== 4'd6) begin
        n_fail++;
        $display("FAIL bp_hold %0d: got d=%h v=%b op=%0d/%0d, expected 0500/1/0/6",
                 i, res_data, res_valid, op_a, op_b);
      end
    end
    res_ready = 1;
    wait_done(cyc);
    n_tests++;
    if (err_cnt !== 9'd64 || err_sum !== 16'd64 || err_max !== 8'd1) begin
      n_fail++;
      $display("FAIL bp_metrics: got %0d/%0d/%0d, expected 64/64/1",
               err_cnt, err_sum, err_max);
    end
    @(posedge clk); #1;
    n_tests++;
    if (xfers !== 256 || exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL bp_xfers: got %0d left %0d, expected 256/0",
               xfers, exp_q.size());
    end
  endtask

  task automatic test_ignore_start;
    int cyc, k;
    start_sweep(1);
    repeat (50) @(posedge clk);
    #1 start = 1;
    @(posedge clk); #1 start = 0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(op_a == 4'hF && op_b == 4'hF && res_valid && res_ready) &&
               k < 400);
    @(posedge clk); #1 res_ready = 0; start = 1;
    @(posedge clk); #1 start = 0;
    n_tests++;
    if (busy !== 1'b1 || res_valid !== 1'b1 || res_data !== 16'hFFE0) begin
      n_fail++;
      $display("FAIL ign_drain: got busy=%b v=%b d=%h, expected 1/1/ffe0",
               busy, res_valid, res_data);
    end
    @(posedge clk); #1 res_ready = 1;
    wait_done(cyc);
    n_tests++;
    if (err_cnt !== 9'd64 || err_sum !== 16'd64 || err_max !== 8'd1) begin
      n_fail++;
      $display("FAIL ign_metrics: got %0d/%0d/%0d, expected 64/64/1",
               err_cnt, err_sum, err_max);
    end
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (done_cnt !== 1 || busy !== 1'b0 || xfers !== 256) begin
      n_fail++;
      $display("FAIL ign_single_done: got done=%0d busy=%b xfers=%0d, expected 1/0/256",
               done_cnt, busy, xfers);
    end
  endtask

  task automatic test_reset_mid;
    int cyc, k;
    start_sweep(1);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (xfers < 100 && k < 400);
    @(posedge clk); #1 rst = 1;
    mon_en = 0;
    #1;
    n_tests++;
    if ({op_a, op_b, res_valid, res_data, busy, done,
         err_cnt, err_sum, err_max} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: op=%h/%h v=%b d=%h busy=%b m=%h/%h/%h, expected all 0",
               op_a, op_b, res_valid, res_data, busy,
               err_cnt, err_sum, err_max);
    end
    @(posedge clk); #1 rst = 0;
    mon_en = 1;
    start_sweep(1);
    wait_done(cyc);
    n_tests++;
    if (cyc !== 257 || err_cnt !== 9'd64 || err_sum !== 16'd64 ||
        err_max !== 8'd1) begin
      n_fail++;
      $display("FAIL rst_mid_resweep: got cyc=%0d m=%0d/%0d/%0d, expected 257/64/64/1",
               cyc, err_cnt, err_sum, err_max);
    end
    @(posedge clk); #1;
    n_tests++;
    if (xfers !== 256 || exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL rst_mid_xfers: got %0d left %0d, expected 256/0",
               xfers, exp_q.size());
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    start_sweep(1);
    wait_done(cyc);
    n_tests++;
    if (err_cnt !== exp_cnt[8:0] || err_sum !== exp_sum[15:0] ||
        err_max !== exp_max[7:0] || xfers !== 256) begin
      n_fail++;
      $display("FAIL b2b_first: got %0d/%0d/%0d x%0d, expected %0d/%0d/%0d x256",
               err_cnt, err_sum, err_max, xfers, exp_cnt, exp_sum, exp_max);
    end
    start_sweep(0);
    n_tests++;
    if ({err_cnt, err_sum, err_max} !== '0) begin
      n_fail++;
      $display("FAIL b2b_clear: got %0d/%0d/%0d, expected 0/0/0",
               err_cnt, err_sum, err_max);
    end
    wait_done(cyc);
    n_tests++;
    if (err_cnt !== exp_cnt[8:0] || err_sum !== exp_sum[15:0] ||
        err_max !== exp_max[7:0] || cyc !== 257) begin
      n_fail++;
      $display("FAIL b2b_second: got %0d/%0d/%0d cyc=%0d, expected %0d/%0d/%0d cyc=257",
               err_cnt, err_sum, err_max, cyc, exp_cnt, exp_sum, exp_max);
    end
    @(posedge clk); #1;
    n_tests++;
    if (xfers !== 256 || exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL b2b_xfers: got %0d left %0d, expected 256/0",
               xfers, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_exact();
    test_lsb_zero();
    test_backpressure();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
